// File: rtl/axi_dma_write.sv
// Single-beat AXI4 write master bridging a simple valid/ready databus write port.
// One request in flight at a time; AW, W and B phases run strictly one after another.
module axi_dma_write #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 30,
    parameter int USE_RAM = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  ready,
    output logic [0:0]            m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [0:0]            m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [0:0]            m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    // state | meaning
    // IDLE  | waiting for a databus request
    // ADDR  | awvalid high with the latched address
    // DATA  | wvalid high with the latched data/strobes (single beat)
    // RESP  | bready high, waiting for the write response
    // DONE  | one-cycle ready pulse (registered completion or empty-strobe request)

    localparam int   STRB_W   = DATA_W / 8;
    localparam int   SIZE_LOG = $clog2(STRB_W);
    localparam logic RAM_MODE = (USE_RAM != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t              state;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [STRB_W-1:0]   strb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        if (|wstrb) begin
                            addr_q    <= addr;
                            data_q    <= wdata;
                            strb_q    <= wstrb;
                            awvalid_q <= 1'b1;
                            state     <= S_ADDR;
                        end else begin
                            // nothing to write: complete without touching the bus
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_ADDR: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_axi_wready) begin
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (RAM_MODE) begin
                            state <= S_IDLE;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // In RAM mode the completion is signalled in the B handshake cycle itself.
    assign ready = done_q | (RAM_MODE & bready_q & m_axi_bvalid);

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(SIZE_LOG);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wlast   = wvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

    // Response id and status carry no information for this master.
    logic unused_bresp;
    assign unused_bresp = ^{m_axi_bid, m_axi_bresp};

endmodule

// File: tb/tb_axi_dma_write.sv
// Bench for axi_dma_write: one USE_RAM=1 and one USE_RAM=0 instance sharing a behavioural
// AXI slave with byte-strobed memory; a per-cycle compare process checks protocol and ready timing.
module tb_axi_dma_write;
    localparam int DW = 256;
    localparam int AW = 30;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid, sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          awready, wready, bvalid;
    logic [0:0]    bid;
    logic [1:0]    bresp;

    logic          valid_i   [2];
    logic [0:0]    awid_i    [2];
    logic [AW-1:0] awaddr_i  [2];
    logic [7:0]    awlen_i   [2];
    logic [2:0]    awsize_i  [2];
    logic [1:0]    awburst_i [2];
    logic [0:0]    awlock_i  [2];
    logic [3:0]    awcache_i [2];
    logic [2:0]    awprot_i  [2];
    logic [3:0]    awqos_i   [2];
    logic          awvalid_i [2];
    logic [DW-1:0] wdata_i   [2];
    logic [SW-1:0] wstrb_i   [2];
    logic          wlast_i   [2];
    logic          wvalid_i  [2];
    logic          bready_i  [2];
    logic          ready_i   [2];

    assign valid_i[0] = valid & ~sel;
    assign valid_i[1] = valid & sel;

    axi_dma_write #(.DATA_W(DW), .ADDR_W(AW), .USE_RAM(1)) u_ram (
        .clk(clk), .rst(rst), .valid(valid_i[0]), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready_i[0]),
        .m_axi_awid(awid_i[0]), .m_axi_awaddr(awaddr_i[0]), .m_axi_awlen(awlen_i[0]),
        .m_axi_awsize(awsize_i[0]), .m_axi_awburst(awburst_i[0]), .m_axi_awlock(awlock_i[0]),
        .m_axi_awcache(awcache_i[0]), .m_axi_awprot(awprot_i[0]), .m_axi_awqos(awqos_i[0]),
        .m_axi_awvalid(awvalid_i[0]), .m_axi_awready(awready),
        .m_axi_wdata(wdata_i[0]), .m_axi_wstrb(wstrb_i[0]), .m_axi_wlast(wlast_i[0]),
        .m_axi_wvalid(wvalid_i[0]), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready_i[0])
    );

    axi_dma_write #(.DATA_W(DW), .ADDR_W(AW), .USE_RAM(0)) u_reg (
        .clk(clk), .rst(rst), .valid(valid_i[1]), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready_i[1]),
        .m_axi_awid(awid_i[1]), .m_axi_awaddr(awaddr_i[1]), .m_axi_awlen(awlen_i[1]),
        .m_axi_awsize(awsize_i[1]), .m_axi_awburst(awburst_i[1]), .m_axi_awlock(awlock_i[1]),
        .m_axi_awcache(awcache_i[1]), .m_axi_awprot(awprot_i[1]), .m_axi_awqos(awqos_i[1]),
        .m_axi_awvalid(awvalid_i[1]), .m_axi_awready(awready),
        .m_axi_wdata(wdata_i[1]), .m_axi_wstrb(wstrb_i[1]), .m_axi_wlast(wlast_i[1]),
        .m_axi_wvalid(wvalid_i[1]), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready_i[1])
    );

    // selected instance as seen by the shared slave and checker
    logic          awvalid, wvalid, wlast, bready, ready;
    logic [AW-1:0] awaddr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    assign awvalid = awvalid_i[sel];
    assign wvalid  = wvalid_i[sel];
    assign wlast   = wlast_i[sel];
    assign bready  = bready_i[sel];
    assign ready   = ready_i[sel];
    assign awaddr  = awaddr_i[sel];
    assign m_wdata = wdata_i[sel];
    assign m_wstrb = wstrb_i[sel];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural AXI slave with memory ----------------
    int aw_stall = 0, w_stall = 0, b_stall = 0;
    int aw_n = 0, w_n = 0, b_n = 0;
    int n_w = 0, n_b = 0;
    logic b_pend = 1'b0;
    logic p_aw = 1'b0, p_w = 1'b0, p_b = 1'b0;
    logic [AW-1:0] h_awaddr, last_aw;
    logic [DW-1:0] h_wdata;
    logic [SW-1:0] h_wstrb;
    logic [AW-1:0] aw_log[$];
    logic [DW-1:0] mem[logic [AW-1:0]];

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 1'b0; bresp = 2'b00;
        last_aw = '0; h_awaddr = '0; h_wdata = '0; h_wstrb = '0;
    end

    always begin
        logic [DW-1:0] line;
        @(posedge clk);
        #2;
        if (p_aw) begin
            aw_log.push_back(h_awaddr);
            last_aw = h_awaddr;
            aw_n = 0;
        end
        if (p_w) begin
            line = mem.exists(last_aw) ? mem[last_aw] : '0;
            for (int i = 0; i < SW; i++)
                if (h_wstrb[i]) line[8*i +: 8] = h_wdata[8*i +: 8];
            mem[last_aw] = line;
            n_w++;
            w_n = 0;
            b_pend = 1'b1;
            b_n = 0;
        end
        if (p_b) begin
            b_pend = 1'b0;
            n_b++;
        end
        if (rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            aw_n = 0; w_n = 0; b_n = 0; b_pend = 1'b0;
            p_aw = 1'b0; p_w = 1'b0; p_b = 1'b0;
        end else begin
            awready = awvalid && (aw_n >= aw_stall);
            if (awvalid) aw_n++;
            wready = wvalid && (w_n >= w_stall);
            if (wvalid) w_n++;
            bvalid = b_pend && (b_n >= b_stall);
            if (b_pend) b_n++;
            bresp = 2'($urandom_range(0, 3));
            bid   = 1'($urandom_range(0, 1));
            p_aw = awvalid & awready;
            h_awaddr = awaddr;
            p_w = wvalid & wready;
            h_wdata = m_wdata;
            h_wstrb = m_wstrb;
            p_b = bvalid & bready;
        end
    end

    // ---------------- per-cycle checker ----------------
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [SW-1:0] cur_wstrb = '0;
    logic          cur_zero = 1'b0;
    logic valid_d = 1'b0, ready_d = 1'b0, rst_d = 1'b1, zs_d = 1'b0, bhs_d = 1'b0;
    logic awv_d = 1'b0, awr_d = 1'b0, wv_d = 1'b0, wr_d = 1'b0;
    logic first_c, exp_ready;
    int   n_ready = 0;

    always @(negedge clk) begin
        first_c = valid && (!valid_d || ready_d);
        if (!rst) begin
            // RAM mode: ready coincides with the B handshake; registered mode: one cycle later
            exp_ready = zs_d || (sel ? bhs_d : (bvalid & bready));
            chk("ready_timing", ready, exp_ready);
            chk("aw_w_exclusive", awvalid & wvalid, 1'b0);
            if (!rst_d && awv_d && !awr_d) chk("awvalid_hold", awvalid, 1'b1);
            if (!rst_d && wv_d && !wr_d) chk("wvalid_hold", wvalid, 1'b1);
            if (awvalid) begin
                chk("awaddr", awaddr, cur_addr);
                chk("awlen", awlen_i[sel], 8'd0);
                chk("awsize", awsize_i[sel], 3'd5);
                chk("awburst", awburst_i[sel], 2'b01);
                chk("aw_const", {awid_i[sel], awlock_i[sel], awcache_i[sel], awprot_i[sel], awqos_i[sel]},
                    {1'b0, 1'b0, 4'b0011, 3'b000, 4'b0000});
            end
            if (wvalid) begin
                chk("wdata", m_wdata, cur_wdata);
                chk("wstrb", m_wstrb, cur_wstrb);
                chk("wlast", wlast, 1'b1);
            end
            if (cur_zero) chk("zero_strobe_no_traffic", awvalid | wvalid, 1'b0);
            if (ready) n_ready++;
        end
        zs_d    = first_c && (wstrb == '0) && !rst;
        bhs_d   = bvalid && bready && !rst;
        valid_d = valid;
        ready_d = ready;
        rst_d   = rst;
        awv_d   = awvalid;
        awr_d   = awready;
        wv_d    = wvalid;
        wr_d    = wready;
    end

    // ---------------- master stimulus ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            output int lat);
        @(posedge clk);
        #1;
        addr = a; wdata = d; wstrb = s; valid = 1'b1;
        cur_addr = a; cur_wdata = d; cur_wstrb = s; cur_zero = (s == '0);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=none required=ready within 200 cycles");
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] p;
        for (int j = 0; j < 8; j++) p[32*j +: 32] = 32'hC0DE0000 + 32'(k << 8) + 32'(j);
        return p;
    endfunction

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    localparam logic [DW-1:0] P1 =
        256'h00112233_44556677_8899AABB_CCDDEEFF_FEDCBA98_76543210_DEADBEEF_CAFEF00D;

    initial begin
        int lat, base_aw, base_w, found;
        rst = 1'b1; valid = 1'b0; sel = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", ready_i[i], 1'b0);
            chk("rst_valids", {awvalid_i[i], wvalid_i[i], bready_i[i]}, 3'b000);
            chk("rst_latched", {awaddr_i[i], wdata_i[i], wstrb_i[i]}, '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single write, slave always ready
        do_write(30'h1000, P1, '1, lat);
        chk("single_latency", lat, 3);
        go_idle();
        chk("single_aw_count", aw_log.size(), 1);
        chk("single_awaddr", aw_log[0], 30'h1000);
        chk("single_w_count", n_w, 1);
        chk("single_mem", rd(30'h1000), P1);

        // 16 back-to-back writes
        aw_log.delete();
        for (int k = 0; k < 16; k++) begin
            do_write(30'h1000 + 30'(32 * k), pat(k), '1, lat);
            chk("b2b_latency", lat, 3);
        end
        go_idle();
        chk("b2b_aw_count", aw_log.size(), 16);
        for (int k = 0; k < 16; k++) begin
            chk("b2b_aw_order", aw_log[k], 30'h1000 + 30'(32 * k));
            chk("b2b_mem", rd(30'h1000 + 30'(32 * k)), pat(k));
        end
        chk("b2b_mem_literal", rd(30'h1060), 256'hC0DE0307_C0DE0306_C0DE0305_C0DE0304_C0DE0303_C0DE0302_C0DE0301_C0DE0300);

        // partial strobes merge into the existing line
        do_write(30'h1000, '1, 32'h0000FFFF, lat);
        go_idle();
        chk("partial_mem", rd(30'h1000), {pat(0)[255:128], {128{1'b1}}});

        // stalled slave
        aw_stall = 3; w_stall = 2; b_stall = 4;
        base_w = n_w;
        do_write(30'h2000, P1, '1, lat);
        go_idle();
        chk("stall_latency", lat, 12);
        chk("stall_w_count", n_w - base_w, 1);
        chk("stall_mem", rd(30'h2000), P1);
        aw_stall = 0; w_stall = 0; b_stall = 0;

        // zero-strobe request
        base_aw = aw_log.size();
        do_write(30'h3000, P1, '0, lat);
        go_idle();
        chk("zero_latency", lat, 1);
        chk("zero_aw_count", aw_log.size(), base_aw);
        chk("zero_mem_untouched", mem.exists(30'h3000), 1'b0);

        // reset during the data phase
        w_stall = 50;
        base_w = n_w;
        @(posedge clk);
        #1;
        addr = 30'h3800; wdata = P1; wstrb = '1; valid = 1'b1;
        cur_addr = 30'h3800; cur_wdata = P1; cur_wstrb = '1; cur_zero = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wvalid) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid_reached_data", found, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 1'b0;
        w_stall = 0;
        @(negedge clk);
        chk("rst_mid_wvalid", wvalid, 1'b0);
        chk("rst_mid_ready", ready, 1'b0);
        chk("rst_mid_others", {awvalid, bready, awaddr}, '0);
        do_write(30'h4000, pat(7), '1, lat);
        go_idle();
        chk("after_rst_latency", lat, 3);
        chk("after_rst_mem", rd(30'h4000), pat(7));
        chk("after_rst_w_count", n_w - base_w, 1);
        chk("aborted_not_written", mem.exists(30'h3800), 1'b0);

        // registered-ready instance
        @(posedge clk);
        #1;
        sel = 1'b1;
        do_write(30'h5000, P1, '1, lat);
        go_idle();
        chk("reg_latency", lat, 4);
        @(negedge clk);
        chk("reg_ready_width", ready, 1'b0);
        chk("reg_mem", rd(30'h5000), P1);
        aw_stall = 3; w_stall = 2; b_stall = 4;
        do_write(30'h5020, pat(9), '1, lat);
        go_idle();
        chk("reg_stall_latency", lat, 13);
        chk("reg_stall_mem", rd(30'h5020), pat(9));
        aw_stall = 0; w_stall = 0; b_stall = 0;
        do_write(30'h5040, P1, '0, lat);
        go_idle();
        chk("reg_zero_latency", lat, 1);
        chk("reg_zero_untouched", mem.exists(30'h5040), 1'b0);

        repeat (4) @(posedge clk);
        chk("ready_pulse_total", n_ready, 24);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_dma_write.md
AXI_DMA_WRITE -- requirements
Module: axi_dma_write

Interface
REQ-001 Parameter DATA_W, default 256, data width of the databus and AXI W channel in bits (multiple of 8, power of 2).
REQ-002 Parameter ADDR_W, default 30, byte-address width of the databus and AXI AW channel.
REQ-003 Parameter USE_RAM, default 0: 1 = ready combinational in the B-handshake cycle; 0 = ready registered, one cycle later.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 valid  in  1  databus write request, held until ready.
REQ-007 addr  in  ADDR_W  byte address of request.
REQ-008 wdata  in  DATA_W  write data.
REQ-009 wstrb  in  DATA_W/8  byte enables.
REQ-010 ready  out  1  one-cycle completion pulse.
REQ-011 m_axi_awid(1), awaddr(ADDR_W), awlen(8), awsize(3), awburst(2), awlock(1), awcache(4), awprot(3), awqos(4), awvalid(1)  out; m_axi_awready(1)  in.
REQ-012 m_axi_wdata(DATA_W), wstrb(DATA_W/8), wlast(1), wvalid(1)  out; m_axi_wready(1)  in.
REQ-013 m_axi_bid(1), bresp(2), bvalid(1)  in; m_axi_bready(1)  out.

Function
REQ-014 Each accepted request SHALL produce exactly one single-beat AXI4 write: awlen=0, wlast=1 with wvalid.
REQ-015 Constant outputs: awid=0, awsize=log2(DATA_W/8), awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=3'b000, awqos=0.
REQ-016 FSM states IDLE, ADDR, DATA, RESP, DONE.
REQ-017 IDLE: valid=1 and wstrb!=0 -> latch addr/wdata/wstrb, go ADDR next cycle.
REQ-018 IDLE: valid=1 and wstrb==0 -> no AXI traffic, ready asserted following cycle (DONE path).
REQ-019 ADDR: awvalid=1, awaddr=latched addr unchanged; awvalid&awready -> DATA.
REQ-020 DATA: wvalid=1, wdata/wstrb=latched values; wvalid&wready -> RESP.
REQ-021 RESP: bready=1; bvalid&bready -> USE_RAM=1: ready=1 same cycle, go IDLE; USE_RAM=0: go DONE.
REQ-022 DONE: ready=1 for exactly one cycle, then IDLE.
REQ-023 AW, W, B handshakes strictly sequential; awvalid and wvalid never both high.
REQ-024 valid, awvalid, wvalid held stable with payload until handshake; payload never changes mid-transaction.
REQ-025 bresp and bid ignored; any bresp completes the transfer.
REQ-026 Next request accepted no earlier than the cycle after ready; the master's valid in the ready cycle does not start a new transfer.
REQ-027 Arbitrary stall on awready, wready, bvalid SHALL be tolerated with no timeout.

Reset
REQ-028 rst=1 at a clock edge: state IDLE; ready, awvalid, wvalid, bready = 0; latched registers cleared to 0.
REQ-029 Reset mid-transaction abandons it immediately; no ready pulse; outputs return to reset values next cycle.
REQ-030 rst dominates all other inputs.

Verification
REQ-031 DATA_W=256, USE_RAM=1, write addr 0x1000, wdata=pattern, wstrb all ones, slave always ready -> one AW (awaddr 0x1000, awlen 0, awsize 5, awburst 1), one W beat with wlast=1, ready pulse in the bvalid cycle; memory holds pattern.
REQ-032 16 back-to-back writes at 0x1000 + 0x20*k, k=0..15 -> 16 single-beat bursts in order; memory read-back matches all 16 lines.
REQ-033 awready low 3 cycles, wready low 2, bvalid delayed 4 -> valid signals held stable, payload unchanged, exactly one ready pulse.
REQ-034 USE_RAM=0 -> ready asserted exactly one cycle after the B handshake, width one cycle.
REQ-035 wstrb=0 request -> no awvalid/wvalid ever asserted, ready one cycle later.
REQ-036 rst asserted during DATA state -> wvalid=0 and no ready next cycle; subsequent request completes normally.
